// File: rtl/csr_trap_ctrl.sv
// Sequencer between decode/execute and the machine-mode CSR file.
// Handles CSRRW/CSRRS/CSRRC, ECALL and MRET in four phases: IDLE, READ, WRITE, RESP.
module csr_trap_ctrl #(
    parameter int              XLEN           = 32,
    parameter int              CSR_ADDR_WIDTH = 2,
    parameter logic [XLEN-1:0] ECALL_CAUSE    = 32'd11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [11:0]               req_csr_num,
    input  logic [XLEN-1:0]           req_src,
    input  logic                      req_src_zero,
    input  logic [XLEN-1:0]           req_pc,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XLEN-1:0]           resp_rd_data,
    output logic                      resp_rd_we,
    output logic                      resp_redirect,
    output logic [XLEN-1:0]           resp_redirect_pc,
    output logic                      resp_illegal,
    output logic [CSR_ADDR_WIDTH-1:0] csr_rd_addr_out,
    input  logic [XLEN-1:0]           csr_rd_data_in,
    output logic                      csr_wr_en_out,
    output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_out_1,
    output logic [XLEN-1:0]           csr_wr_data_out_1,
    output logic [CSR_ADDR_WIDTH-1:0] csr_wr_addr_out_2,
    output logic [XLEN-1:0]           csr_wr_data_out_2
);

    localparam logic [2:0] OP_RW    = 3'b000;
    localparam logic [2:0] OP_RS    = 3'b001;
    localparam logic [2:0] OP_RC    = 3'b010;
    localparam logic [2:0] OP_ECALL = 3'b100;
    localparam logic [2:0] OP_MRET  = 3'b101;

    localparam logic [CSR_ADDR_WIDTH-1:0] IDX_MSTATUS = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] IDX_MTVEC   = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] IDX_MEPC    = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] IDX_MCAUSE  = CSR_ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                op_q;
    logic [CSR_ADDR_WIDTH-1:0] idx_q;
    logic [XLEN-1:0]           src_q;
    logic                      src_zero_q;
    logic [XLEN-1:0]           pc_q;
    logic                      illegal_q;
    logic [XLEN-1:0]           old_q;

    logic                      accept;
    logic                      req_mapped;
    logic [CSR_ADDR_WIDTH-1:0] req_idx;
    logic                      req_is_csr;
    logic                      req_illegal;
    logic                      op_is_csr;
    logic [XLEN-1:0]           new_val;
    logic                      wr_req;

    // Compact index of the architectural CSR number.
    always_comb begin
        req_mapped = 1'b1;
        req_idx    = IDX_MSTATUS;
        case (req_csr_num)
            12'h300: req_idx = IDX_MSTATUS;
            12'h305: req_idx = IDX_MTVEC;
            12'h341: req_idx = IDX_MEPC;
            12'h342: req_idx = IDX_MCAUSE;
            default: req_mapped = 1'b0;
        endcase
    end

    assign req_is_csr  = (req_op == OP_RW) || (req_op == OP_RS) || (req_op == OP_RC);
    assign req_illegal = req_is_csr ? !req_mapped
                                    : !((req_op == OP_ECALL) || (req_op == OP_MRET));
    assign accept      = (state_q == S_IDLE) && req_valid;
    assign op_is_csr   = (op_q == OP_RW) || (op_q == OP_RS) || (op_q == OP_RC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            idx_q      <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            pc_q       <= '0;
            illegal_q  <= 1'b0;
            old_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= req_op;
                idx_q      <= req_idx;
                src_q      <= req_src;
                src_zero_q <= req_src_zero;
                pc_q       <= req_pc;
                illegal_q  <= req_illegal;
            end
            if (state_q == S_READ) begin
                old_q <= csr_rd_data_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = req_illegal ? S_RESP : S_READ;
            S_READ:  state_d = S_WRITE;
            S_WRITE: state_d = S_RESP;
            S_RESP:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_RS:   new_val = old_q | src_q;
            OP_RC:   new_val = old_q & ~src_q;
            default: new_val = src_q;
        endcase
    end

    // Read port and write port sequencing; both write ports share one enable.
    always_comb begin
        csr_rd_addr_out   = '0;
        wr_req            = 1'b0;
        csr_wr_addr_out_1 = '0;
        csr_wr_data_out_1 = '0;
        csr_wr_addr_out_2 = '0;
        csr_wr_data_out_2 = '0;
        if (state_q == S_READ) begin
            if (op_q == OP_ECALL)     csr_rd_addr_out = IDX_MTVEC;
            else if (op_q == OP_MRET) csr_rd_addr_out = IDX_MEPC;
            else                      csr_rd_addr_out = idx_q;
        end
        if (state_q == S_WRITE) begin
            if (op_is_csr) begin
                // Set/clear with a zero operand is a pure read.
                wr_req            = (op_q == OP_RW) || !src_zero_q;
                csr_wr_addr_out_1 = idx_q;
                csr_wr_data_out_1 = new_val;
                csr_wr_addr_out_2 = idx_q;
                csr_wr_data_out_2 = new_val;
            end else if (op_q == OP_ECALL) begin
                wr_req            = 1'b1;
                csr_wr_addr_out_1 = IDX_MEPC;
                csr_wr_data_out_1 = pc_q;
                csr_wr_addr_out_2 = IDX_MCAUSE;
                csr_wr_data_out_2 = ECALL_CAUSE;
            end
        end
    end

    assign csr_wr_en_out = wr_req && !rst;
    assign req_ready     = (state_q == S_IDLE);

    always_comb begin
        resp_valid       = 1'b0;
        resp_rd_data     = '0;
        resp_rd_we       = 1'b0;
        resp_redirect    = 1'b0;
        resp_redirect_pc = '0;
        resp_illegal     = 1'b0;
        if (state_q == S_RESP) begin
            resp_valid = 1'b1;
            if (illegal_q) begin
                resp_illegal = 1'b1;
            end else if (op_is_csr) begin
                resp_rd_data = old_q;
                resp_rd_we   = 1'b1;
            end else begin
                resp_redirect    = 1'b1;
                resp_redirect_pc = old_q;
            end
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl with a small behavioural CSR file attached.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [11:0] req_csr_num;
    logic [31:0] req_src;
    logic        req_src_zero;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rd_data;
    logic        resp_rd_we;
    logic        resp_redirect;
    logic [31:0] resp_redirect_pc;
    logic        resp_illegal;
    logic [1:0]  csr_rd_addr_out;
    logic [31:0] csr_rd_data_in;
    logic        csr_wr_en_out;
    logic [1:0]  csr_wr_addr_out_1;
    logic [31:0] csr_wr_data_out_1;
    logic [1:0]  csr_wr_addr_out_2;
    logic [31:0] csr_wr_data_out_2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    csr_trap_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_csr_num(req_csr_num), .req_src(req_src), .req_src_zero(req_src_zero),
        .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_data(resp_rd_data),
        .resp_rd_we(resp_rd_we), .resp_redirect(resp_redirect),
        .resp_redirect_pc(resp_redirect_pc), .resp_illegal(resp_illegal),
        .csr_rd_addr_out(csr_rd_addr_out), .csr_rd_data_in(csr_rd_data_in),
        .csr_wr_en_out(csr_wr_en_out),
        .csr_wr_addr_out_1(csr_wr_addr_out_1), .csr_wr_data_out_1(csr_wr_data_out_1),
        .csr_wr_addr_out_2(csr_wr_addr_out_2), .csr_wr_data_out_2(csr_wr_data_out_2)
    );

    // CSR file model: combinational read, registered dual write, plus a preload port.
    logic [31:0] csr_m [4];
    logic        poke_en = 1'b0;
    logic [1:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_cnt = 0;
    logic [1:0]  last_a1, last_a2;
    logic [31:0] last_d1, last_d2;

    assign csr_rd_data_in = csr_m[csr_rd_addr_out];

    always @(posedge clk) begin
        if (poke_en) csr_m[poke_addr] <= poke_data;
        if (csr_wr_en_out) begin
            csr_m[csr_wr_addr_out_1] <= csr_wr_data_out_1;
            csr_m[csr_wr_addr_out_2] <= csr_wr_data_out_2;
            last_a1 <= csr_wr_addr_out_1;
            last_d1 <= csr_wr_data_out_1;
            last_a2 <= csr_wr_addr_out_2;
            last_d2 <= csr_wr_data_out_2;
            wr_cnt  <= wr_cnt + 1;
        end
    end

    // Results of the most recent issue() call.
    int          r_lat;
    int          r_pulses;
    logic [31:0] r_rd_data;
    logic        r_rd_we;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic        r_illegal;

    task automatic poke(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [11:0] num,
                         input logic [31:0] src, input logic sz, input logic [31:0] pc);
        int c0;
        @(negedge clk);
        c0 = wr_cnt;
        req_valid = 1'b1; req_op = op; req_csr_num = num;
        req_src = src; req_src_zero = sz; req_pc = pc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = 1;
        @(negedge clk);
        while (!resp_valid && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
        end
        if (!resp_valid) begin
            tests++; fails++;
            $display("FAIL resp_timeout op=%b got no resp_valid within 20 cycles", op);
        end
        r_pulses      = wr_cnt - c0;
        r_rd_data     = resp_rd_data;
        r_rd_we       = resp_rd_we;
        r_redirect    = resp_redirect;
        r_redirect_pc = resp_redirect_pc;
        r_illegal     = resp_illegal;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || csr_wr_en_out !== 1'b0 ||
            resp_rd_we !== 1'b0 || resp_redirect !== 1'b0 || resp_illegal !== 1'b0 ||
            csr_rd_addr_out !== 2'd0) begin
            fails++;
            $display("FAIL reset_state rdy=%b vld=%b we=%b rdwe=%b redir=%b ill=%b rda=%0d, want 1 0 0 0 0 0 0",
                     req_ready, resp_valid, csr_wr_en_out, resp_rd_we, resp_redirect,
                     resp_illegal, csr_rd_addr_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_csrrw;
        poke(2'd1, 32'h8000_0100);
        issue(3'b000, 12'h305, 32'h8000_0200, 1'b0, 32'h0);
        tests++;
        if (r_lat !== 3) begin fails++; $display("FAIL rw_latency got %0d want 3", r_lat); end
        tests++;
        if (r_rd_data !== 32'h8000_0100 || r_rd_we !== 1'b1 || r_redirect !== 1'b0) begin
            fails++;
            $display("FAIL rw_resp got data=%h we=%b redir=%b want 80000100 1 0",
                     r_rd_data, r_rd_we, r_redirect);
        end
        tests++;
        if (r_pulses !== 1 || csr_m[1] !== 32'h8000_0200) begin
            fails++;
            $display("FAIL rw_write got pulses=%0d mtvec=%h want 1 80000200", r_pulses, csr_m[1]);
        end
        issue(3'b001, 12'h305, 32'h0, 1'b1, 32'h0);
        tests++;
        if (r_rd_data !== 32'h8000_0200 || r_rd_we !== 1'b1 || r_pulses !== 0) begin
            fails++;
            $display("FAIL rs_zero got data=%h we=%b pulses=%0d want 80000200 1 0",
                     r_rd_data, r_rd_we, r_pulses);
        end
    endtask

    task automatic test_set_clear;
        poke(2'd0, 32'h0000_1800);
        issue(3'b001, 12'h300, 32'h8, 1'b0, 32'h0);
        tests++;
        if (r_rd_data !== 32'h1800 || csr_m[0] !== 32'h1808 || r_pulses !== 1) begin
            fails++;
            $display("FAIL csrrs got old=%h mstatus=%h pulses=%0d want 1800 1808 1",
                     r_rd_data, csr_m[0], r_pulses);
        end
        issue(3'b010, 12'h300, 32'h800, 1'b0, 32'h0);
        tests++;
        if (r_rd_data !== 32'h1808 || csr_m[0] !== 32'h1008 || r_pulses !== 1) begin
            fails++;
            $display("FAIL csrrc got old=%h mstatus=%h pulses=%0d want 1808 1008 1",
                     r_rd_data, csr_m[0], r_pulses);
        end
    endtask

    task automatic test_ecall_mret;
        poke(2'd1, 32'h8000_0100);
        poke(2'd0, 32'h0000_1008);
        issue(3'b100, 12'h000, 32'h0, 1'b0, 32'h8000_0040);
        tests++;
        if (r_redirect !== 1'b1 || r_redirect_pc !== 32'h8000_0100 || r_rd_we !== 1'b0) begin
            fails++;
            $display("FAIL ecall_resp got redir=%b pc=%h we=%b want 1 80000100 0",
                     r_redirect, r_redirect_pc, r_rd_we);
        end
        tests++;
        if (r_pulses !== 1 || last_a1 !== 2'd2 || last_d1 !== 32'h8000_0040 ||
            last_a2 !== 2'd3 || last_d2 !== 32'd11) begin
            fails++;
            $display("FAIL ecall_write got pulses=%0d p1=%0d:%h p2=%0d:%h want 1 2:80000040 3:b",
                     r_pulses, last_a1, last_d1, last_a2, last_d2);
        end
        tests++;
        if (csr_m[2] !== 32'h8000_0040 || csr_m[3] !== 32'd11 || csr_m[0] !== 32'h1008) begin
            fails++;
            $display("FAIL ecall_state got mepc=%h mcause=%h mstatus=%h want 80000040 b 1008",
                     csr_m[2], csr_m[3], csr_m[0]);
        end
        issue(3'b101, 12'h000, 32'h0, 1'b0, 32'h0);
        tests++;
        if (r_pulses !== 0 || r_redirect !== 1'b1 || r_redirect_pc !== 32'h8000_0040 ||
            r_rd_we !== 1'b0) begin
            fails++;
            $display("FAIL mret got pulses=%0d redir=%b pc=%h we=%b want 0 1 80000040 0",
                     r_pulses, r_redirect, r_redirect_pc, r_rd_we);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] snap [4];
        for (int i = 0; i < 4; i++) snap[i] = csr_m[i];
        issue(3'b000, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        tests++;
        if (r_illegal !== 1'b1 || r_lat !== 1 || r_pulses !== 0 || r_rd_we !== 1'b0 ||
            r_redirect !== 1'b0) begin
            fails++;
            $display("FAIL illegal_csr got ill=%b lat=%0d pulses=%0d we=%b redir=%b want 1 1 0 0 0",
                     r_illegal, r_lat, r_pulses, r_rd_we, r_redirect);
        end
        issue(3'b111, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0);
        tests++;
        if (r_illegal !== 1'b1 || r_lat !== 1 || r_pulses !== 0 || r_rd_we !== 1'b0) begin
            fails++;
            $display("FAIL illegal_op got ill=%b lat=%0d pulses=%0d we=%b want 1 1 0 0",
                     r_illegal, r_lat, r_pulses, r_rd_we);
        end
        tests++;
        if (csr_m[0] !== snap[0] || csr_m[1] !== snap[1] || csr_m[2] !== snap[2] ||
            csr_m[3] !== snap[3]) begin
            fails++;
            $display("FAIL illegal_state got %h %h %h %h want %h %h %h %h",
                     csr_m[0], csr_m[1], csr_m[2], csr_m[3], snap[0], snap[1], snap[2], snap[3]);
        end
    endtask

    task automatic test_backpressure;
        int          c0;
        logic [31:0] held;
        poke(2'd2, 32'h0000_0ABC);
        resp_ready = 1'b0;
        issue(3'b000, 12'h341, 32'h0000_1234, 1'b0, 32'h0);
        c0   = wr_cnt;
        held = resp_rd_data;
        tests++;
        if (held !== 32'h0ABC) begin
            fails++; $display("FAIL bp_data got %h want abc", held);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rd_data !== 32'h0ABC ||
                resp_rd_we !== 1'b1 || wr_cnt !== c0) begin
                fails++;
                $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b data=%h we=%b extra_wr=%0d want 1 0 abc 1 0",
                         i, resp_valid, req_ready, resp_rd_data, resp_rd_we, wr_cnt - c0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || csr_m[2] !== 32'h1234) begin
            fails++;
            $display("FAIL bp_release got rdy=%b vld=%b mepc=%h want 1 0 1234",
                     req_ready, resp_valid, csr_m[2]);
        end
    endtask

    task automatic test_reset_mid;
        int c0;
        poke(2'd0, 32'h0000_0055);
        @(negedge clk);
        c0 = wr_cnt;
        req_valid = 1'b1; req_op = 3'b000; req_csr_num = 12'h300;
        req_src = 32'hDEAD_BEEF; req_src_zero = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Now in WRITE: the write is pending until reset is raised.
        tests++;
        if (csr_wr_en_out !== 1'b1) begin
            fails++; $display("FAIL mid_pre_write got wr_en=%b want 1", csr_wr_en_out);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (csr_wr_en_out !== 1'b0) begin
            fails++; $display("FAIL mid_rst_wr_en got %b want 0", csr_wr_en_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || wr_cnt !== c0 ||
            csr_m[0] !== 32'h55) begin
            fails++;
            $display("FAIL mid_rst_after got rdy=%b vld=%b writes=%0d mstatus=%h want 1 0 0 55",
                     req_ready, resp_valid, wr_cnt - c0, csr_m[0]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) csr_m[i] = '0;
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_csr_num = '0;
        req_src = '0; req_src_zero = 1'b0; req_pc = '0; resp_ready = 1'b1;
        test_reset();
        test_csrrw();
        test_set_clear();
        test_ecall_mret();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
